// File: rtl/mem_walker_loop_ctrl_pkg.sv
// Shared types and helpers for the mem_walker loop sequencer.
// Holds the FSM state enum, the default count width and the zero-is-one substitution.
package mem_walker_loop_ctrl_pkg;

  localparam int unsigned ITER_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StRun    = 2'd2,
    StFinish = 2'd3
  } state_e;

  // A stored count of 0 means "run this loop once".
  function automatic logic [ITER_W_DEFAULT-1:0] zero_is_one(
    input logic [ITER_W_DEFAULT-1:0] count
  );
    return (count == '0) ? ITER_W_DEFAULT'(1) : count;
  endfunction

endpackage

// File: rtl/loop_odometer.sv
// Mixed-radix nested loop counter. Slot 0 is outermost, slot NUM_LOOPS-1 innermost;
// wrap[i] is high when counters i..NUM_LOOPS-1 all sit at their maximum.
module loop_odometer #(
  parameter int unsigned NUM_LOOPS = 32,
  parameter int unsigned ITER_W    = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             en,
  input  logic                             clr,
  input  logic [NUM_LOOPS-1:0][ITER_W-1:0] max_val,
  output logic [NUM_LOOPS-1:0]             wrap
);

  logic [NUM_LOOPS-1:0][ITER_W-1:0] cnt_q, cnt_d;
  logic [NUM_LOOPS-1:0]             at_max;
  // Bit NUM_LOOPS is a constant carry-in for the innermost counter.
  logic [NUM_LOOPS:0]               all_max;
  logic                             acc;

  always_comb begin
    at_max  = '0;
    all_max = '0;
    acc     = 1'b1;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      at_max[i] = (cnt_q[i] == max_val[i]);
    end
    all_max[NUM_LOOPS] = 1'b1;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      acc = 1'b1;
      for (int j = i; j < NUM_LOOPS; j++) begin
        acc = acc & at_max[j];
      end
      all_max[i] = acc;
    end
  end

  assign wrap = all_max[NUM_LOOPS-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        if (all_max[i+1]) begin
          cnt_d[i] = at_max[i] ? '0 : cnt_q[i] + ITER_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_walker_loop_ctrl.sv
// Loop sequencer for one mem_walker_stride_group: stores per-group loop counts,
// launches the walker and runs the nested counters for the selected group.
module mem_walker_loop_ctrl
  import mem_walker_loop_ctrl_pkg::*;
#(
  parameter int unsigned LOOP_ID_W      = 5,
  parameter int unsigned GROUP_ID_W     = 2,
  parameter int unsigned ITER_W         = ITER_W_DEFAULT,
  parameter int unsigned NUM_MAX_LOOPS  = 1 << LOOP_ID_W,
  parameter int unsigned NUM_MAX_GROUPS = 1 << GROUP_ID_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_iter_v,
  input  logic [ITER_W-1:0]        cfg_iter,
  input  logic [GROUP_ID_W-1:0]    cfg_group_id,
  input  logic                     block_done,
  input  logic                     start,
  input  logic [GROUP_ID_W-1:0]    start_group_id,
  input  logic                     stall,
  output logic                     walker_start,
  output logic [NUM_MAX_LOOPS:0]   iter_done,
  output logic [GROUP_ID_W-1:0]    loop_group_id,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  localparam int unsigned PTR_W = LOOP_ID_W + 1;

  state_e state_q, state_d;

  logic [NUM_MAX_GROUPS-1:0][NUM_MAX_LOOPS-1:0][ITER_W-1:0] counts_q, counts_d;
  logic [NUM_MAX_GROUPS-1:0][PTR_W-1:0]                     wptr_q, wptr_d;
  logic [GROUP_ID_W-1:0]                                    group_q, group_d;
  logic                                                     cfg_err_q, cfg_err_d;

  logic                                  idle;
  logic                                  run_en;
  logic                                  clr;
  logic [PTR_W-1:0]                      cur_wptr;
  logic [LOOP_ID_W-1:0]                  wr_slot;
  logic [NUM_MAX_LOOPS-1:0][ITER_W-1:0]  max_val;
  logic [NUM_MAX_LOOPS-1:0]              wrap;

  assign idle     = (state_q == StIdle);
  assign run_en   = (state_q == StRun) && !stall;
  assign cur_wptr = wptr_q[cfg_group_id];
  assign wr_slot  = cur_wptr[LOOP_ID_W-1:0];

  // Configuration store: only mutable while idle, any attempt while busy is flagged.
  always_comb begin
    counts_d  = counts_q;
    wptr_d    = wptr_q;
    cfg_err_d = cfg_err_q;
    if (idle) begin
      if (block_done) begin
        for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
          for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
            counts_d[g][l] = ITER_W'(1);
          end
        end
        wptr_d = '0;
      end else if (cfg_iter_v) begin
        if (cur_wptr == PTR_W'(NUM_MAX_LOOPS)) begin
          cfg_err_d = 1'b1;
        end else begin
          counts_d[cfg_group_id][wr_slot] = cfg_iter;
          wptr_d[cfg_group_id]            = cur_wptr + PTR_W'(1);
        end
      end
    end else if (cfg_iter_v || block_done) begin
      cfg_err_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    clr     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLaunch;
          group_d = start_group_id;
        end
      end
      StLaunch: begin
        clr     = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        if (!stall && wrap[0]) begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      group_q   <= '0;
      cfg_err_q <= 1'b0;
      wptr_q    <= '0;
      for (int g = 0; g < NUM_MAX_GROUPS; g++) begin
        for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
          counts_q[g][l] <= ITER_W'(1);
        end
      end
    end else begin
      state_q   <= state_d;
      group_q   <= group_d;
      cfg_err_q <= cfg_err_d;
      wptr_q    <= wptr_d;
      counts_q  <= counts_d;
    end
  end

  always_comb begin
    max_val = '0;
    for (int l = 0; l < NUM_MAX_LOOPS; l++) begin
      max_val[l] = zero_is_one(counts_q[group_q][l]) - ITER_W'(1);
    end
  end

  loop_odometer #(
    .NUM_LOOPS (NUM_MAX_LOOPS),
    .ITER_W    (ITER_W)
  ) u_odometer (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (run_en),
    .clr     (clr),
    .max_val (max_val),
    .wrap    (wrap)
  );

  assign walker_start  = (state_q == StLaunch);
  assign busy          = !idle;
  assign done          = (state_q == StFinish);
  assign iter_done     = run_en ? {1'b1, wrap} : '0;
  assign loop_group_id = group_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_mem_walker_loop_ctrl.sv
// Directed self-checking bench for mem_walker_loop_ctrl; each run is captured over a
// fixed 16-cycle window and compared against hand-derived per-cycle bit masks.
module tb_mem_walker_loop_ctrl;

  logic        clk;
  logic        reset_n;
  logic        cfg_iter_v;
  logic [15:0] cfg_iter;
  logic [1:0]  cfg_group_id;
  logic        block_done;
  logic        start;
  logic [1:0]  start_group_id;
  logic        stall;
  logic        walker_start;
  logic [32:0] iter_done;
  logic [1:0]  loop_group_id;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_walker_loop_ctrl u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_iter_v     (cfg_iter_v),
    .cfg_iter       (cfg_iter),
    .cfg_group_id   (cfg_group_id),
    .block_done     (block_done),
    .start          (start),
    .start_group_id (start_group_id),
    .stall          (stall),
    .walker_start   (walker_start),
    .iter_done      (iter_done),
    .loop_group_id  (loop_group_id),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] g, input logic [15:0] val);
    cfg_iter_v   = 1'b1;
    cfg_group_id = g;
    cfg_iter     = val;
    tick();
    cfg_iter_v   = 1'b0;
  endtask

  // Offset k is the k-th cycle after start was presented (offset 0 = start cycle).
  task automatic run_group(
    input string       tag,
    input logic [1:0]  g,
    input logic [15:0] smask,
    input logic [15:0] xstart,
    input logic [15:0] cmask,
    input logic [15:0] e_ws,
    input logic [15:0] e_top,
    input logic [15:0] e_id1,
    input logic [15:0] e_id0,
    input logic [15:0] e_done,
    input logic [15:0] e_busy
  );
    logic [15:0] c_ws, c_top, c_mid, c_id1, c_id0, c_done, c_busy;
    c_ws = '0; c_top = '0; c_mid = '0; c_id1 = '0; c_id0 = '0; c_done = '0; c_busy = '0;
    start_group_id = g;
    cfg_group_id   = g;
    cfg_iter       = 16'd7;
    for (int k = 0; k < 16; k++) begin
      start      = (k == 0) || xstart[k];
      stall      = smask[k];
      cfg_iter_v = cmask[k];
      #1;
      c_ws[k]   = walker_start;
      c_top[k]  = iter_done[32];
      c_mid[k]  = iter_done[2];
      c_id1[k]  = iter_done[1];
      c_id0[k]  = iter_done[0];
      c_done[k] = done;
      c_busy[k] = busy;
      tick();
    end
    start      = 1'b0;
    stall      = 1'b0;
    cfg_iter_v = 1'b0;
    check_eq({tag, ".walker_start"}, 64'(c_ws), 64'(e_ws));
    check_eq({tag, ".iter_done_top"}, 64'(c_top), 64'(e_top));
    check_eq({tag, ".iter_done2"}, 64'(c_mid), 64'(e_top));
    check_eq({tag, ".iter_done1"}, 64'(c_id1), 64'(e_id1));
    check_eq({tag, ".iter_done0"}, 64'(c_id0), 64'(e_id0));
    check_eq({tag, ".done"}, 64'(c_done), 64'(e_done));
    check_eq({tag, ".busy"}, 64'(c_busy), 64'(e_busy));
    check_eq({tag, ".group_id"}, 64'(loop_group_id), 64'(g));
  endtask

  initial begin
    reset_n        = 1'b0;
    cfg_iter_v     = 1'b0;
    cfg_iter       = '0;
    cfg_group_id   = '0;
    block_done     = 1'b0;
    start          = 1'b0;
    start_group_id = '0;
    stall          = 1'b0;
    #1;
    check_eq("reset.outputs",
             64'({walker_start, iter_done, loop_group_id, busy, done, cfg_err}), 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Group 1 = {2,3}, group 3 = {0,4}.
    cfg_write(2'd1, 16'd2);
    cfg_write(2'd1, 16'd3);
    cfg_write(2'd3, 16'd0);
    cfg_write(2'd3, 16'd4);
    check_eq("cfg.no_err", 64'(cfg_err), 64'd0);

    run_group("basic", 2'd1, 16'h0000, 16'h0000, 16'h0000,
              16'h0002, 16'h00FC, 16'h0090, 16'h0080, 16'h0100, 16'h01FE);

    // Stall at run cycles 3-4; a start coincident with done must be ignored.
    run_group("stall", 2'd1, 16'h0030, 16'h0400, 16'h0000,
              16'h0002, 16'h03CC, 16'h0240, 16'h0200, 16'h0400, 16'h07FE);

    run_group("zero", 2'd3, 16'h0000, 16'h0000, 16'h0000,
              16'h0002, 16'h003C, 16'h0020, 16'h0020, 16'h0040, 16'h007E);

    check_eq("busy.err_before", 64'(cfg_err), 64'd0);
    run_group("busy", 2'd1, 16'h0000, 16'h0000, 16'h0008,
              16'h0002, 16'h00FC, 16'h0090, 16'h0080, 16'h0100, 16'h01FE);
    check_eq("busy.err_set", 64'(cfg_err), 64'd1);
    block_done = 1'b1;
    tick();
    block_done = 1'b0;
    run_group("cleared", 2'd1, 16'h0000, 16'h0000, 16'h0000,
              16'h0002, 16'h0004, 16'h0004, 16'h0004, 16'h0008, 16'h000E);
    check_eq("busy.err_sticky", 64'(cfg_err), 64'd1);

    // Reset in the third RUN cycle of a 5-iteration nest.
    cfg_write(2'd0, 16'd5);
    start_group_id = 2'd0;
    start          = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check_eq("rst.busy_before", 64'(busy), 64'd1);
    check_eq("rst.top_before", 64'(iter_done[32]), 64'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rst.busy", 64'(busy), 64'd0);
    check_eq("rst.iter_done", 64'(iter_done), 64'd0);
    check_eq("rst.done", 64'(done), 64'd0);
    check_eq("rst.err", 64'(cfg_err), 64'd0);
    #2;
    reset_n = 1'b1;
    tick();
    run_group("post_rst", 2'd0, 16'h0000, 16'h0000, 16'h0000,
              16'h0002, 16'h0004, 16'h0004, 16'h0004, 16'h0008, 16'h000E);

    // Group 2 = {2,2}; group 0 gets 32 writes {2,1,...,1} then one extra that must drop.
    cfg_write(2'd2, 16'd2);
    cfg_write(2'd2, 16'd2);
    cfg_write(2'd0, 16'd2);
    for (int i = 1; i < 32; i++) begin
      cfg_write(2'd0, 16'd1);
    end
    check_eq("ovf.err_before", 64'(cfg_err), 64'd0);
    cfg_write(2'd0, 16'd3);
    check_eq("ovf.err_set", 64'(cfg_err), 64'd1);
    run_group("ovf_g0", 2'd0, 16'h0000, 16'h0000, 16'h0000,
              16'h0002, 16'h000C, 16'h000C, 16'h0008, 16'h0010, 16'h001E);
    run_group("ovf_g2", 2'd2, 16'h0000, 16'h0000, 16'h0000,
              16'h0002, 16'h003C, 16'h0028, 16'h0020, 16'h0040, 16'h007E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
